// File: rtl/mult_div_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer and owner of the HI/LO pair.
// Radix-2 iteration, one bit per cycle. A shared 2*WIDTH accumulator holds
// {hi, lo} of the product when multiplying, or {remainder, quotient} when
// dividing.
`timescale 1ns / 1ps

module mult_div_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             iStart,
    input  logic [1:0]       iOp,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iMTHI,
    input  logic             iMTLO,
    output logic [WIDTH-1:0] oHI,
    output logic [WIDTH-1:0] oLO,
    output logic             oBusy,
    output logic             oDone
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opnd_q;    // multiplicand or divisor (magnitude)
    logic                 is_div_q;
    logic                 negq_q;
    logic                 negr_q;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 done_q;

    // Operand decode in IDLE
    logic                 op_div, op_signed, a_neg, b_neg, div_zero;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic                 cnt_last;

    assign op_div    = iOp[1];
    assign op_signed = ~iOp[0];
    assign a_neg     = op_signed & iA[WIDTH-1];
    assign b_neg     = op_signed & iB[WIDTH-1];
    assign a_abs     = a_neg ? -iA : iA;
    assign b_abs     = b_neg ? -iB : iB;
    assign div_zero  = op_div && (iB == '0);
    assign cnt_last  = (cnt_q == CW'(WIDTH - 1));

    // One iteration step: shift-add for multiply, restoring shift-subtract for divide
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift, div_diff;
    logic [2*WIDTH-1:0]   div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        // Borrow out of the (WIDTH+1)-bit subtract means the divisor did not fit
        if (div_diff[WIDTH]) begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction applied in FIX
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    always_comb begin
        prod_fix = negq_q ? -acc_q : acc_q;
        quot_fix = negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // FSM state register
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (iStart) begin
                    state_d = div_zero ? StFix : StCalc;
                end
            end
            StCalc: begin
                if (cnt_last) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath, HI/LO and done pulse
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state_q == StFix);
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (iStart) begin
                        is_div_q <= op_div;
                        if (div_zero) begin
                            // Preload {rem, quot} so FIX commits HI=raw iA, LO=all ones
                            acc_q  <= {iA, {WIDTH{1'b1}}};
                            opnd_q <= '0;
                            negq_q <= 1'b0;
                            negr_q <= 1'b0;
                        end else if (op_div) begin
                            acc_q  <= {{WIDTH{1'b0}}, a_abs};
                            opnd_q <= b_abs;
                            negq_q <= a_neg ^ b_neg;
                            negr_q <= a_neg;
                        end else begin
                            acc_q  <= {{WIDTH{1'b0}}, b_abs};
                            opnd_q <= a_abs;
                            negq_q <= a_neg ^ b_neg;
                            negr_q <= 1'b0;
                        end
                    end else begin
                        if (iMTHI) hi_q <= iA;
                        if (iMTLO) lo_q <= iA;
                    end
                end
                StCalc: begin
                    cnt_q <= cnt_q + 1'b1;
                    acc_q <= is_div_q ? div_next : mul_next;
                end
                StFix: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    assign oHI   = hi_q;
    assign oLO   = lo_q;
    assign oBusy = (state_q != StIdle);
    assign oDone = done_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer: directed table, hand-written
// corner sequences and randomized ops against an arithmetic reference model.
`timescale 1ns / 1ps

module tb_mult_div_sequencer;

    logic        iCLK = 1'b0;
    logic        iRST_n = 1'b0;
    logic        iStart = 1'b0;
    logic [1:0]  iOp = 2'b00;
    logic [31:0] iA = '0;
    logic [31:0] iB = '0;
    logic        iMTHI = 1'b0;
    logic        iMTLO = 1'b0;
    logic [31:0] oHI, oLO;
    logic        oBusy, oDone;

    int vectors = 0;
    int miscompares = 0;
    int ops_started = 0;
    int done_seen = 0;

    mult_div_sequencer #(.WIDTH(32)) dut (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .iStart (iStart),
        .iOp    (iOp),
        .iA     (iA),
        .iB     (iB),
        .iMTHI  (iMTHI),
        .iMTLO  (iMTLO),
        .oHI    (oHI),
        .oLO    (oLO),
        .oBusy  (oBusy),
        .oDone  (oDone)
    );

    always #5 iCLK = ~iCLK;

    // Count every cycle with oDone high
    always @(posedge iCLK) begin
        if (oDone === 1'b1) done_seen++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, MIPS semantics
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else if (op == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    hi = sr[31:0];
                    lo = sq[31:0];
                end else begin
                    p  = ua / ub;
                    hi = 32'(ua % ub);
                    lo = p[31:0];
                end
            end
        endcase
    endfunction

    // Called at posedge+1; returns at the sample where oDone is high.
    // inject_at >= 0 drives a stray start + MT writes at that busy cycle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int inject_at, input string name);
        int lat, busy_cnt, cyc;
        logic [31:0] hi_before, lo_before;
        lat = (op[1] && b == 0) ? 1 : 33;
        hi_before = oHI;
        lo_before = oLO;
        ops_started++;
        iStart = 1'b1; iOp = op; iA = a; iB = b;
        @(posedge iCLK); #1;
        iStart = 1'b0; iMTHI = 1'b0; iMTLO = 1'b0;
        iOp = 2'($urandom); iA = $urandom; iB = $urandom;
        check({name, " busy after start"}, 64'(oBusy), 64'd1);
        check({name, " no done at start"}, 64'(oDone), 64'd0);
        check({name, " HI held at start"}, 64'(oHI), 64'(hi_before));
        check({name, " LO held at start"}, 64'(oLO), 64'(lo_before));
        busy_cnt = 0;
        cyc = 0;
        while (oDone !== 1'b1 && cyc < 100) begin
            if (oBusy === 1'b1) busy_cnt++;
            if (cyc == inject_at) begin
                iStart = 1'b1; iMTHI = 1'b1; iMTLO = 1'b1; iOp = 2'b01;
                iA = 32'hDEAD_BEEF; iB = 32'h1;
            end
            @(posedge iCLK); #1;
            cyc++;
            if (cyc == inject_at + 1) begin
                iStart = 1'b0; iMTHI = 1'b0; iMTLO = 1'b0;
                check({name, " MTHI ignored"}, 64'(oHI), 64'(hi_before));
                check({name, " MTLO ignored"}, 64'(oLO), 64'(lo_before));
            end
        end
        check({name, " done seen"}, 64'(oDone), 64'd1);
        check({name, " latency"}, 64'(cyc), 64'(lat));
        check({name, " busy cycles"}, 64'(busy_cnt), 64'(lat));
        check({name, " busy low at done"}, 64'(oBusy), 64'd0);
        check({name, " HI"}, 64'(oHI), 64'(exp_hi));
        check({name, " LO"}, 64'(oLO), 64'(exp_lo));
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [31:0] eh, el, ra, rb;
        logic [1:0]  rop;

        tbl.push_back('{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, "multu max*2"});
        tbl.push_back('{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult -3*7"});
        tbl.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2"});
        tbl.push_back('{2'b11, 32'd100,       32'h0000_0000, 32'd100,       32'hFFFF_FFFF, "divu 100/0"});
        tbl.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div ovf"});
        tbl.push_back('{2'b10, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, "div min/0"});
        tbl.push_back('{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div 7/-2"});
        tbl.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult min*min"});
        tbl.push_back('{2'b11, 32'd50,        32'd7,         32'd1,         32'd7,         "divu 50/7"});
        tbl.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu max*max"});

        // Reset state
        #2;
        check("reset HI", 64'(oHI), 64'd0);
        check("reset LO", 64'(oLO), 64'd0);
        check("reset busy", 64'(oBusy), 64'd0);
        check("reset done", 64'(oDone), 64'd0);
        repeat (2) @(posedge iCLK);
        #2 iRST_n = 1'b1;
        @(posedge iCLK); #1;

        // Directed table
        foreach (tbl[i]) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, -1, tbl[i].name);
            @(posedge iCLK); #1;
            check({tbl[i].name, " done one cycle"}, 64'(oDone), 64'd0);
        end

        // MT writes in IDLE
        iMTHI = 1'b1; iA = 32'h1234_5678;
        @(posedge iCLK); #1;
        iMTHI = 1'b0;
        check("mthi HI", 64'(oHI), 64'h1234_5678);
        iMTLO = 1'b1; iA = 32'h9ABC_DEF0;
        @(posedge iCLK); #1;
        iMTLO = 1'b0;
        check("mtlo LO", 64'(oLO), 64'h9ABC_DEF0);
        check("mtlo HI kept", 64'(oHI), 64'h1234_5678);
        iMTHI = 1'b1; iMTLO = 1'b1; iA = 32'h0BAD_F00D;
        @(posedge iCLK); #1;
        iMTHI = 1'b0; iMTLO = 1'b0;
        check("mt both HI", 64'(oHI), 64'h0BAD_F00D);
        check("mt both LO", 64'(oLO), 64'h0BAD_F00D);

        // Start with MT writes in the same cycle: MT dropped
        iMTHI = 1'b1; iMTLO = 1'b1;
        do_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, -1, "start+mt");
        @(posedge iCLK); #1;

        // Stray start and MT at busy cycle 10 of MULTU 3x5
        do_op(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 9, "busy ignore");
        @(posedge iCLK); #1;
        check("no stray op after busy ignore", 64'(oBusy), 64'd0);

        // Reset mid-divide after preloading HI/LO
        iMTHI = 1'b1; iMTLO = 1'b1; iA = 32'hAAAA_5555;
        @(posedge iCLK); #1;
        iMTHI = 1'b0; iMTLO = 1'b0;
        check("preload HI", 64'(oHI), 64'hAAAA_5555);
        iStart = 1'b1; iOp = 2'b11; iA = 32'd50; iB = 32'd7;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        repeat (14) begin @(posedge iCLK); #1; end
        check("busy before reset", 64'(oBusy), 64'd1);
        #2 iRST_n = 1'b0;
        #1;
        check("async reset HI", 64'(oHI), 64'd0);
        check("async reset LO", 64'(oLO), 64'd0);
        check("async reset busy", 64'(oBusy), 64'd0);
        @(posedge iCLK); #2;
        iRST_n = 1'b1;
        @(posedge iCLK); #1;
        check("idle after reset", 64'(oBusy), 64'd0);
        do_op(2'b11, 32'd50, 32'd7, 32'd1, 32'd7, -1, "divu after reset");

        // Back-to-back: start in the oDone cycle
        do_op(2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd0, 32'd30, -1, "b2b first");
        do_op(2'b10, 32'd1000, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FF72, -1, "b2b second");
        @(posedge iCLK); #1;

        // Randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2, 3:    rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            ref_model(rop, ra, rb, eh, el);
            do_op(rop, ra, rb, eh, el, -1, $sformatf("rand%0d op%0d %h,%h", n, rop, ra, rb));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge iCLK); #1;
            end
        end

        repeat (3) @(posedge iCLK);
        #1;
        check("total done pulses", 64'(done_seen), 64'(ops_started));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
